// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch resolution, fetch redirect/BHT training, flush sequencing and perf counters
module branch_resolve_unit #(
  parameter int ADDR_BIT = 10,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                stall_in,
  input  logic                valid_ex,
  input  logic                is_branch,
  input  logic                is_jump,
  input  logic                br_cond,
  input  logic [ADDR_BIT-1:0] pc_ex,
  input  logic [ADDR_BIT-1:0] pred_addr,
  input  logic [ADDR_BIT-1:0] target,
  output logic                isbj,
  output logic                keep_pc,
  output logic                gone,
  output logic [ADDR_BIT-1:0] g_addr,
  output logic [ADDR_BIT-1:0] s_addr,
  output logic [ADDR_BIT-1:0] pc_before_g,
  output logic                flush,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    mispredict_cnt
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state;
  logic [3:0] fcnt;
  logic ev, taken, mis, bj;
  logic [ADDR_BIT-1:0] seq, actual;
  always_comb begin
    ev = en & valid_ex & ~stall_in & (state == IDLE);
    bj = is_branch | is_jump;
    taken = is_jump | (is_branch & br_cond);
    seq = pc_ex + {{(ADDR_BIT-1){1'b0}}, 1'b1};
    actual = taken ? target : seq;
    mis = pred_addr != actual;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt <= '0;
      isbj <= 1'b0;
      keep_pc <= 1'b1;
      gone <= 1'b0;
      g_addr <= '0;
      s_addr <= '0;
      pc_before_g <= '0;
      flush <= 1'b0;
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else if (!en) begin
      isbj <= 1'b0;
      keep_pc <= 1'b1;
    end else begin
      isbj <= ev & bj;
      keep_pc <= ~(ev & mis);
      if (ev) begin
        gone <= taken;
        g_addr <= target;
        s_addr <= seq;
        pc_before_g <= pc_ex;
        if (bj && branch_cnt != '1) branch_cnt <= branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (mis && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state == IDLE) begin
        if (ev && mis) begin
          state <= FLUSH;
          flush <= 1'b1;
          fcnt <= 4'(FLUSH_CYCLES - 1);
        end
      end else if (fcnt == 4'd0) begin
        state <= IDLE;
        flush <= 1'b0;
      end else begin
        fcnt <= fcnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of resolution, flush, stall, wrap, reset and counter saturation
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst, en, stall_in, valid_ex, is_branch, is_jump, br_cond;
  logic [9:0] pc_ex, pred_addr, target;
  logic isbj, keep_pc, gone, flush;
  logic [9:0] g_addr, s_addr, pc_before_g;
  logic [31:0] branch_cnt, mispredict_cnt;
  logic isbj2, keep_pc2, gone2, flush2;
  logic [9:0] g_addr2, s_addr2, pc_before_g2;
  logic [3:0] branch_cnt2, mispredict_cnt2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .en(en), .stall_in(stall_in), .valid_ex(valid_ex),
    .is_branch(is_branch), .is_jump(is_jump), .br_cond(br_cond), .pc_ex(pc_ex),
    .pred_addr(pred_addr), .target(target), .isbj(isbj), .keep_pc(keep_pc),
    .gone(gone), .g_addr(g_addr), .s_addr(s_addr), .pc_before_g(pc_before_g),
    .flush(flush), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .stall_in(stall_in), .valid_ex(valid_ex),
    .is_branch(is_branch), .is_jump(is_jump), .br_cond(br_cond), .pc_ex(pc_ex),
    .pred_addr(pred_addr), .target(target), .isbj(isbj2), .keep_pc(keep_pc2),
    .gone(gone2), .g_addr(g_addr2), .s_addr(s_addr2), .pc_before_g(pc_before_g2),
    .flush(flush2), .branch_cnt(branch_cnt2), .mispredict_cnt(mispredict_cnt2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic j, input logic c,
                       input logic [9:0] pc, input logic [9:0] pr, input logic [9:0] tg);
    valid_ex = v; is_branch = b; is_jump = j; br_cond = c;
    pc_ex = pc; pred_addr = pr; target = tg;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; stall_in = 1'b0;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    tick; tick;
    rst = 1'b0;
    chk("rst_isbj", isbj, 0);
    chk("rst_keep", keep_pc, 1);
    chk("rst_flush", flush, 0);
    chk("rst_bcnt", branch_cnt, 0);
    chk("rst_mcnt", mispredict_cnt, 0);
    chk("rst_saddr", s_addr, 0);
    // correct taken prediction
    drive(1, 1, 0, 1, 10'h010, 10'h040, 10'h040);
    tick;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    chk("t1_isbj", isbj, 1);
    chk("t1_gone", gone, 1);
    chk("t1_keep", keep_pc, 1);
    chk("t1_flush", flush, 0);
    chk("t1_gaddr", g_addr, 10'h040);
    chk("t1_bcnt", branch_cnt, 1);
    chk("t1_mcnt", mispredict_cnt, 0);
    tick;
    chk("t1_isbj_pulse", isbj, 0);
    chk("t1_gone_hold", gone, 1);
    // not-taken mispredict, wrong-path instruction during flush
    drive(1, 1, 0, 0, 10'h020, 10'h080, 10'h050);
    tick;
    drive(1, 1, 0, 1, 10'h030, 10'h123, 10'h070);
    chk("t2_keep", keep_pc, 0);
    chk("t2_gone", gone, 0);
    chk("t2_saddr", s_addr, 10'h021);
    chk("t2_pcbg", pc_before_g, 10'h020);
    chk("t2_flush1", flush, 1);
    chk("t2_mcnt", mispredict_cnt, 1);
    chk("t2_bcnt", branch_cnt, 2);
    tick;
    chk("t2_flush2", flush, 1);
    chk("t2_keep_wp", keep_pc, 1);
    chk("t2_isbj_wp", isbj, 0);
    chk("t2_pcbg_wp", pc_before_g, 10'h020);
    tick;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    chk("t2_flush_end", flush, 0);
    chk("t2_isbj_wp2", isbj, 0);
    chk("t2_mcnt_wp", mispredict_cnt, 1);
    chk("t2_bcnt_wp", branch_cnt, 2);
    // BHT false hit on a plain ALU op
    drive(1, 0, 0, 0, 10'h005, 10'h100, 10'h000);
    tick;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    chk("t3_isbj", isbj, 0);
    chk("t3_keep", keep_pc, 0);
    chk("t3_saddr", s_addr, 10'h006);
    chk("t3_bcnt", branch_cnt, 2);
    chk("t3_mcnt", mispredict_cnt, 2);
    tick; tick;
    chk("t3_flush_end", flush, 0);
    // jump at the top of memory wraps sequential address, held off by stall
    drive(1, 0, 1, 0, 10'h3FF, 10'h000, 10'h000);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_stall_isbj", isbj, 0);
    end
    stall_in = 1'b0;
    tick;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    chk("t4_isbj", isbj, 1);
    chk("t4_keep", keep_pc, 1);
    chk("t4_saddr", s_addr, 10'h000);
    chk("t4_pcbg", pc_before_g, 10'h3FF);
    chk("t4_bcnt", branch_cnt, 3);
    tick;
    chk("t4_once", isbj, 0);
    chk("t4_bcnt_once", branch_cnt, 3);
    // enable low freezes the block
    en = 1'b0;
    drive(1, 1, 0, 1, 10'h060, 10'h000, 10'h090);
    tick;
    chk("en_isbj", isbj, 0);
    chk("en_keep", keep_pc, 1);
    chk("en_mcnt", mispredict_cnt, 2);
    en = 1'b1;
    // branch and jump together behave as a jump
    drive(1, 1, 1, 0, 10'h050, 10'h111, 10'h111);
    tick;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    chk("bj_gone", gone, 1);
    chk("bj_keep", keep_pc, 1);
    chk("bj_bcnt", branch_cnt, 4);
    // reset during flush
    drive(1, 1, 0, 1, 10'h100, 10'h101, 10'h200);
    tick;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    chk("t5_flush", flush, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_flush_rst", flush, 0);
    chk("t5_bcnt_rst", branch_cnt, 0);
    chk("t5_mcnt_rst", mispredict_cnt, 0);
    chk("t5_keep_rst", keep_pc, 1);
    drive(1, 1, 0, 1, 10'h040, 10'h060, 10'h060);
    tick;
    drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
    chk("t5_isbj", isbj, 1);
    chk("t5_keep", keep_pc, 1);
    chk("t5_bcnt", branch_cnt, 1);
    chk("t5_flush_after", flush, 0);
    tick;
    // 4-bit counters saturate at 15
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0, 10'(i), 10'h3AA, 10'h000);
      tick;
      drive(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      tick; tick;
      if (i == 14) chk("sat_15", mispredict_cnt2, 15);
    end
    chk("sat_hold", mispredict_cnt2, 15);
    chk("sat_wide", mispredict_cnt, 16);
    chk("sat_bcnt4", branch_cnt2, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage branch resolver, paired with the fetch-side PC/BHT predictor.
- Takes each instruction's PC and the fetch-time prediction, which is carried down the pipe.
- Computes the real next PC and decides whether the prediction held.
- Drives the redirect/training bundle back to fetch: isbj, keep_pc, gone, g_addr, s_addr, pc_before_g.
- Sequences a fixed-length pipeline flush on a mispredict and keeps saturating performance counters.

Parameters:
- ADDR_BIT, 10, instruction-memory word-address width; PC increments by 1.
- FLUSH_CYCLES, 2, cycles flush stays high after a mispredict (1..15).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global run enable; low freezes the block.
- stall_in  in  1  EX stage stalled; the presented instruction is not consumed.
- valid_ex  in  1  EX holds a real instruction.
- is_branch  in  1  conditional branch.
- is_jump  in  1  unconditional jump or jump-register.
- br_cond  in  1  branch condition result from the ALU.
- pc_ex  in  ADDR_BIT  PC of the EX instruction.
- pred_addr  in  ADDR_BIT  next-PC chosen at fetch for this instruction.
- target  in  ADDR_BIT  resolved branch/jump target.
- isbj  out  1  one-cycle pulse: a branch/jump resolved; BHT write strobe.
- keep_pc  out  1  high means the prediction held; low for one cycle means redirect.
- gone  out  1  actual direction taken.
- g_addr  out  ADDR_BIT  resolved taken target.
- s_addr  out  ADDR_BIT  sequential address, pc_ex+1.
- pc_before_g  out  ADDR_BIT  PC of the resolved instruction; BHT index.
- flush  out  1  squash IF/ID and the EX input.
- branch_cnt  out  CNT_W  resolved branches/jumps.
- mispredict_cnt  out  CNT_W  redirects issued.

Behaviour:
- Resolve event (cycle t): en & valid_ex & !stall_in & state==IDLE.
  - taken = is_jump | (is_branch & br_cond).
  - actual = taken ? target : pc_ex+1, with pc_ex+1 wrapping modulo 2^ADDR_BIT (max address + 1 = 0).
  - mis = (pred_addr != actual).
  - Non-branch instructions also resolve. A BHT false hit (pred_addr != pc_ex+1) counts as a mispredict with gone=0 and isbj=0.
- All outputs are registered; event results appear in cycle t+1:
  - isbj = is_branch|is_jump; gone = taken; g_addr = target; s_addr = pc_ex+1; pc_before_g = pc_ex; keep_pc = !mis.
- isbj and keep_pc==0 are single-cycle pulses. With no event, isbj=0 and keep_pc=1.
  - gone, g_addr, s_addr and pc_before_g hold their last values.
- FSM states are IDLE and FLUSH.
  - IDLE→FLUSH on an event with mis=1; flush rises in t+1 and fcnt loads FLUSH_CYCLES-1.
  - In FLUSH, flush=1 and fcnt decrements each enabled cycle. Exit to IDLE in the cycle after fcnt==0, so flush is high for exactly FLUSH_CYCLES enabled cycles.
  - While in FLUSH, valid_ex is ignored: wrong-path instructions cause no event, counter change or pulse.
- Counters, both saturating at all-ones:
  - branch_cnt += 1 in t+1 for an event with isbj.
  - mispredict_cnt += 1 for an event with mis.
- stall_in=1 blocks the event. The same instruction is resolved once, in the first non-stalled cycle.
- en=0: no events, FSM and fcnt frozen, counters frozen, isbj=0, keep_pc=1, flush holds its value.
- rst (sync): state=IDLE, fcnt=0, isbj=0, keep_pc=1, gone=0, g_addr=s_addr=pc_before_g=0, flush=0, counters=0. A reset during FLUSH aborts the flush in the next cycle.
- rst has priority over en.
- Simultaneous is_branch & is_jump is treated as a jump (taken=1).

Test Plan:
- Correct taken predict: branch, pc_ex=0x010, br_cond=1, target=0x040, pred_addr=0x040 → t+1: isbj=1, gone=1, keep_pc=1, flush=0, branch_cnt=1, mispredict_cnt=0.
- Not-taken mispredict: branch, pc_ex=0x020, br_cond=0, pred_addr=0x080 → t+1: keep_pc=0, gone=0, s_addr=0x021, pc_before_g=0x020. flush high for t+1..t+2. A valid_ex presented at t+1 causes no event. mispredict_cnt=1.
- BHT false hit on ALU op: pc_ex=0x005, pred_addr=0x100 → isbj=0, keep_pc=0, s_addr=0x006, branch_cnt unchanged.
- Wrap and stall: jump at pc_ex=0x3FF, target=0x000, pred_addr=0x000, stall_in held high 3 cycles → no pulse while stalled; exactly one isbj pulse after release, keep_pc=1, s_addr=0x000.
- Reset mid-flush: mispredict, then rst in the first flush cycle → next cycle flush=0, counters=0, keep_pc=1. The next valid branch resolves normally.
- Saturation: preload CNT_W=4 build with 15 mispredicts, then one more → mispredict_cnt stays 15.
